// File: rtl/h80uart_pkg.sv
// h80uart shared types: transmitter states, divisor rounding, frame length.
// Frame length follows H80UART_TX_PARITY_EN (8E1 when defined, else 8N1).
package h80uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

`ifdef H80UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/h80uart_fifo.sv
// h80uart synchronous FIFO; pointers carry an extra MSB to tell full from empty.
module h80uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    import h80uart_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/h80uart_tx.sv
// h80uart buffered transmitter: FIFO, baud counter, shifter and frame FSM.
// Define H80UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module h80uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_en,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_idle,
    output logic                          uart_txp
);
    import h80uart_pkg::*;

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_e   state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic [7:0]  shreg, shreg_d;
    logic        line_d;
    logic        bit_end;
    logic        was_idle;
    logic        fifo_pop;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
`ifdef H80UART_TX_PARITY_EN
    logic        par_q;
`endif

    h80uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .reset   (reset),
        .push    (tx_en),
        .pop     (fifo_pop),
        .wr_data (tx_data),
        .rd_data (fifo_rdata),
        .full    (tx_busy),
        .empty   (fifo_empty),
        .level   (tx_level)
    );

    assign bit_end = (cnt == CW'(DIV - 1));

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        fifo_pop  = 1'b0;
        line_d    = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    cnt_d    = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                line_d = 1'b0;
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_DATA: begin
                line_d = shreg[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef H80UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`ifdef H80UART_TX_PARITY_EN
            S_PARITY: begin
                line_d = par_q;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line and idle flag are registered so the pin never glitches.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            uart_txp <= 1'b1;
            was_idle <= 1'b1;
            tx_idle  <= 1'b1;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_idx_d;
            shreg    <= shreg_d;
            uart_txp <= line_d;
            was_idle <= (state == S_IDLE);
            tx_idle  <= fifo_empty && (state == S_IDLE) && was_idle;
        end
    end

`ifdef H80UART_TX_PARITY_EN
    always_ff @(posedge sysclk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (fifo_pop) begin
            par_q <= ^fifo_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_h80uart_tx.sv
// Bench for h80uart_tx: queue/timeline reference model checked every cycle.
module tb_h80uart_tx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD_R = 60;
    localparam int DEPTH  = 16;
    localparam int DIV    = $rtoi(real'(CLK_HZ) / real'(BAUD_R) + 0.5);
`ifdef H80UART_TX_PARITY_EN
    localparam int FRAME  = 11;
`else
    localparam int FRAME  = 10;
`endif

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_en  = 1'b0;
    logic       tx_busy;
    logic [4:0] tx_level;
    logic       tx_idle;
    logic       uart_txp;

    h80uart_tx #(
        .CLK_FREQ   (CLK_HZ),
        .BAUD       (BAUD_R),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_busy  (tx_busy),
        .tx_level (tx_level),
        .tx_idle  (tx_idle),
        .uart_txp (uart_txp)
    );

    always #5 sysclk = ~sysclk;

    int         errors = 0;
    int         checks = 0;
    int         ecyc = 0;
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int         fstart = -1000000;
    int         next_free = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d",
                   tag, obs, exp, ecyc);
        end
    endtask

    function automatic logic exp_line(input int e);
        int k;
        if (e < fstart || e >= fstart + FRAME * DIV) return 1'b1;
        k = (e - fstart) / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
`ifdef H80UART_TX_PARITY_EN
        if (k == 9) return ^cur;
`endif
        return 1'b1;
    endfunction

    // One clock: advance the model on the edge, compare all outputs after.
    task automatic step();
        bit empty_b, full_b, pop, idle_e;
        @(posedge sysclk);
        ecyc++;
        if (reset) begin
            q.delete();
            fstart    = -1000000;
            next_free = ecyc;
            idle_e    = 1'b1;
        end else begin
            empty_b = (q.size() == 0);
            full_b  = (q.size() >= DEPTH);
            idle_e  = empty_b && (ecyc >= next_free + 1);
            pop     = !empty_b && (ecyc >= next_free);
            if (pop) begin
                cur       = q.pop_front();
                fstart    = ecyc + 1;
                next_free = ecyc + FRAME * DIV + 1;
            end
            if (tx_en && !full_b) q.push_back(tx_data);
        end
        #1;
        chk("level", 32'(tx_level), 32'(q.size()));
        chk("busy", 32'(tx_busy), 32'(q.size() == DEPTH));
        chk("idle", 32'(tx_idle), 32'(idle_e));
        chk("line", 32'(uart_txp), 32'(exp_line(ecyc)));
    endtask

    task automatic push(input logic [7:0] b);
        tx_data = b;
        tx_en   = 1'b1;
        step();
        tx_en   = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic run_until(input int target);
        while (ecyc < target) step();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        step();
        step();
        while (tx_idle !== 1'b1 && n < 20 * FRAME * DIV) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(tx_idle), 32'd1);
    endtask

    initial begin
        int n0;

        for (int i = 0; i < 3; i++) begin
            tx_en = i[0];
            step();
        end
        tx_en = 1'b0;
        chk("rst_txp", 32'(uart_txp), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_level", 32'(tx_level), 32'd0);
        chk("rst_idle", 32'(tx_idle), 32'd1);
        reset = 1'b0;
        step();

        push(8'h55);
        n0 = ecyc;
        step();
        chk("n1_txp_high", 32'(uart_txp), 32'd1);
        chk("n1_idle_low", 32'(tx_idle), 32'd0);
        step();
        chk("n2_start_low", 32'(uart_txp), 32'd0);
        run_until(n0 + 2 + DIV + DIV / 2);
        chk("bit0_of_55", 32'(uart_txp), 32'd1);
        run_until(n0 + 2 + 2 * DIV + DIV / 2);
        chk("bit1_of_55", 32'(uart_txp), 32'd0);
        run_until(n0 + 2 + FRAME * DIV);
        chk("idle_not_yet", 32'(tx_idle), 32'd0);
        step();
        chk("idle_rise", 32'(tx_idle), 32'd1);

        for (int i = 0; i < 18; i++) begin
            push(8'(i));
            if (i == 16) begin
                chk("burst_busy17", 32'(tx_busy), 32'd1);
                chk("burst_level17", 32'(tx_level), 32'd16);
            end
        end
        chk("burst_busy18", 32'(tx_busy), 32'd1);
        chk("burst_drop18", 32'(tx_level), 32'd16);
        wait_idle();

        push(8'h81);
        repeat (20) step();
        push(8'h42);
        run_until(next_free - 1);
        chk("pp_before", 32'(tx_level), 32'd1);
        push(8'h99);
        chk("pp_level", 32'(tx_level), 32'd1);
        wait_idle();

        push(8'hA5);
        n0 = ecyc;
        push(8'h11);
        run_until(n0 + 2 + 4 * DIV + DIV / 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_txp", 32'(uart_txp), 32'd1);
        chk("midrst_level", 32'(tx_level), 32'd0);
        push(8'h3C);
        wait_idle();

`ifdef H80UART_TX_PARITY_EN
        push(8'h07);
        n0 = ecyc;
        run_until(n0 + 2 + 9 * DIV + DIV / 2);
        chk("par_07", 32'(uart_txp), 32'd1);
        wait_idle();
        push(8'h03);
        n0 = ecyc;
        run_until(n0 + 2 + 9 * DIV + DIV / 2);
        chk("par_03", 32'(uart_txp), 32'd0);
        wait_idle();
`endif

        for (int i = 0; i < 3000; i++) begin
            tx_en   = ($urandom_range(7) == 0);
            tx_data = 8'($urandom);
            reset   = ($urandom_range(1499) == 0);
            step();
        end
        tx_en = 1'b0;
        reset = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/h80uart_tx.md
# h80uart_tx

Buffered UART transmitter for the h80 tiny-CPU system, sitting directly downstream of the bus I/O block. It accepts bytes through a one-cycle push handshake into an on-chip FIFO and serializes them as 8N1 frames (optionally 8E1) on the UART TX pin. The CPU can queue a burst of characters without stalling on every byte.

## Interface
Parameters:
- CLK_FREQ, 50000000: sysclk frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- FIFO_DEPTH, 16: FIFO entries; power of two, ≥2.

Ports:
- sysclk  in  1  sole clock; all logic is posedge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to enqueue.
- tx_en  in  1  push strobe; one byte is accepted per cycle with tx_en=1 and tx_busy=0.
- tx_busy  out  1  FIFO full; pushes are ignored while high.
- tx_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx_idle  out  1  FIFO empty and shifter in S_IDLE.
- uart_txp  out  1  serial line; idle high.

## Operation
- Bit period DIV = (CLK_FREQ + BAUD/2) / BAUD, integer rounding. Bit counter counts 0..DIV-1.
- FSM states:
  - S_IDLE: if FIFO is non-empty, pop into the shift register and go to S_START.
  - S_START: line 0 for DIV cycles.
  - S_DATA: 8 bits, LSB first, DIV cycles each.
  - S_PARITY: macro only.
  - S_STOP: line 1 for DIV cycles, then S_IDLE.
- Frames are back-to-back: S_STOP to S_IDLE to pop costs exactly one extra high cycle.
- tx_busy is registered full. A push when tx_busy=1 is dropped silently and has no other effect.
- Push and pop in the same cycle: both take effect and tx_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are decided by the extra pointer MSB.
- tx_data is sampled only on an accepted push. It need not be held afterward.
- Reset values: uart_txp=1, tx_busy=0, tx_level=0, tx_idle=1, state S_IDLE.
- Reset mid-frame:
  - the frame is aborted;
  - uart_txp=1 in the cycle after reset is sampled;
  - FIFO contents are discarded.

## Timing
- Push at edge N into an empty, idle block:
  - tx_level=1 after N.
  - Pop at N+1.
  - uart_txp falls after N+2.
  - tx_idle falls after N+1.
- Frame length is 10·DIV cycles (11·DIV with parity).
- A successor byte already queued starts its start bit 10·DIV+1 cycles after the previous start bit.
- tx_idle rises one cycle after the last stop bit completes.
- tx_level and tx_busy update in the cycle after a push or pop.

## Configuration
- H80UART_TX_PARITY_EN defined:
  - S_PARITY is inserted after S_DATA and drives the even-parity bit (XOR of the 8 data bits) for DIV cycles.
  - Frame is 8E1, 11·DIV cycles.
- Undefined: S_PARITY does not exist, and the frame is 8N1, 10·DIV cycles.

## Structure
- Package h80uart_pkg holds:
  - the state enum (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP);
  - the divisor-rounding function;
  - the frame-length constant.
- Sub-module h80uart_fifo: synchronous FIFO with push/pop, full, empty and level. It is parameterized by width and depth.
- Baud counter, shifter and FSM live in h80uart_tx.

## Test plan
- Reset: hold reset 3 cycles → uart_txp=1, tx_busy=0, tx_level=0, tx_idle=1. Toggling tx_en during reset leaves tx_level=0.
- Single byte (DIV=434): push 0x55 → start bit low from N+2 for 434 cycles, then bits 1,0,1,0,1,0,1,0, then stop high. tx_idle=1 at N+2+4340+1.
- Burst and overflow (DEPTH=16): push 0x00..0x11 on 18 consecutive cycles → tx_busy=1 after the 17th push and 0x11 is dropped. Serial output is 0x00..0x10 in order with no gaps beyond one idle cycle between frames.
- Simultaneous push/pop: push exactly on the pop cycle of a queued byte → tx_level unchanged that cycle and the byte order is preserved.
- Reset mid-frame: assert reset during bit 3 of 0xA5 → uart_txp=1 next cycle, tx_level=0. A following push of 0x3C transmits cleanly.
- Parity (H80UART_TX_PARITY_EN): push 0x07 → parity bit 1. Push 0x03 → parity bit 0. Frame is 11·DIV cycles.
